hazard_ctrl_unit: RTL
=====================

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameter NSTG, default 5, pipeline-register count and width of stall/flush vectors (legal range NSTG >= 4).
REQ-002 Parameter AW, default 5, register-address width.
REQ-003 Parameter MDU_LAT, default 4, multiply/divide occupancy in cycles (legal range MDU_LAT >= 1).
REQ-004 Parameter CNT_W, default 16, width of the event counters.
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  in  1  reset, synchronous, active-low.
REQ-007 Ports id_ex_memread  in  1 and id_ex_rt  in  AW: the EX-stage load flag and the load destination register.
REQ-008 Ports if_id_rs  in  AW and if_id_rt  in  AW: the ID-stage source registers.
REQ-009 Ports ex_branch  in  1 and ex_zero  in  1: an EX-stage branch and its condition; taken = ex_branch & ex_zero.
REQ-010 Port id_jump  in  1  ID-stage jump decoded.
REQ-011 Port mdu_start  in  1  EX-stage multiply/divide issue pulse.
REQ-012 Port stall  out  NSTG  hold vector; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4+ later registers.
REQ-013 Port flush  out  NSTG  clear/bubble vector; same bit mapping as stall.
REQ-014 Port mdu_busy  out  1  high while the FSM is in MDU_WAIT.
REQ-015 Ports stall_cnt  out  CNT_W and flush_cnt  out  CNT_W: saturating event counters.

Function
REQ-016 The FSM SHALL have two states, IDLE and MDU_WAIT, plus a down-counter wcnt of width clog2(MDU_LAT)+1.
REQ-017 IDLE with mdu_start=1 and MDU_LAT>1: the FSM SHALL move to MDU_WAIT and load wcnt=MDU_LAT-2.
REQ-018 IDLE with mdu_start=1 and MDU_LAT=1: the FSM SHALL remain in IDLE.
REQ-019 MDU_WAIT: wcnt SHALL decrement each cycle; at wcnt=0 the FSM SHALL return to IDLE on the next edge.
REQ-020 mdu_start SHALL be ignored outside IDLE.
REQ-021 MDU stall SHALL be asserted whenever (IDLE & mdu_start) | MDU_WAIT, giving exactly MDU_LAT stall cycles per issue.
REQ-022 MDU stall SHALL drive stall[2:0]=1 and flush[3]=1 (bubble into EX/MEM).
REQ-023 Load-use SHALL be detected when id_ex_memread & id_ex_rt!=0 & (id_ex_rt==if_id_rs | id_ex_rt==if_id_rt).
REQ-024 Load-use SHALL drive stall[1:0]=1 and flush[2]=1.
REQ-025 A taken branch SHALL drive flush[2:1]=1 and force stall to 0 in the same cycle.
REQ-026 A jump SHALL drive flush[1]=1.
REQ-027 Priority SHALL be, highest first: taken branch > MDU stall > load-use > jump.
REQ-028 A lower-priority event SHALL contribute no stall or flush bits when a higher-priority event is active.
REQ-029 A taken branch coincident with mdu_start SHALL suppress the MDU stall and SHALL NOT start the FSM.
REQ-030 stall, flush and mdu_busy SHALL be combinational from the inputs and current state; all unused bits SHALL be 0.
REQ-031 stall_cnt SHALL increment by 1 on each clock edge where stall!=0, saturating at 2^CNT_W-1.
REQ-032 flush_cnt SHALL increment by 1 on each clock edge with an effective taken-branch or jump flush; bubble-only flushes (REQ-022, REQ-024) SHALL NOT count; it saturates at 2^CNT_W-1.

Reset
REQ-033 With rst_n=0 at a rising edge: the FSM SHALL go to IDLE, and wcnt, stall_cnt and flush_cnt SHALL be set to 0.
REQ-034 While rst_n=0: stall=0, flush=0 and mdu_busy=0, regardless of the other inputs.
REQ-035 Reset asserted during MDU_WAIT SHALL abort the wait; the first cycle after release is IDLE with no stall.

Verification
REQ-036 Load-use: memread=1, id_ex_rt=8, if_id_rs=8 -> stall=00011, flush=00100, stall_cnt +1; repeated with id_ex_rt=0 -> stall=0, flush=0.
REQ-037 MDU (MDU_LAT=4): mdu_start pulse -> stall=00111 and flush=01000 for exactly 4 cycles, mdu_busy high for cycles 2-4, then 0; stall_cnt=4.
REQ-038 Branch taken during a load-use hit -> stall=00000, flush=00110, flush_cnt +1.
REQ-039 Jump during load-use -> stall=00011, flush=00100, flush_cnt unchanged; jump alone -> flush=00010, flush_cnt +1.
REQ-040 rst_n low in the 2nd MDU_WAIT cycle -> outputs 0 while low; after release, IDLE with all counters 0.
REQ-041 CNT_W=2, stall held 5 cycles -> stall_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: resolves taken-branch, multiply/divide occupancy,
// load-use and jump hazards into per-register stall/flush vectors, with saturating event counters.
module hazard_ctrl_unit #(
  parameter int NSTG    = 5,
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_ex_memread,
  input  logic [AW-1:0]    id_ex_rt,
  input  logic [AW-1:0]    if_id_rs,
  input  logic [AW-1:0]    if_id_rt,
  input  logic             ex_branch,
  input  logic             ex_zero,
  input  logic             id_jump,
  input  logic             mdu_start,
  output logic [NSTG-1:0]  stall,
  output logic [NSTG-1:0]  flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(MDU_LAT) + 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] MDU_WAIT = 1'b1;

  // Issue cycle is itself a stall cycle, so the wait state covers MDU_LAT-1 cycles.
  localparam bit             MULTI_CYC = (MDU_LAT > 1);
  localparam logic [WCW-1:0] WLOAD     = MULTI_CYC ? WCW'(MDU_LAT - 2) : '0;

  logic [0:0]     state;
  logic [0:0]     state_nxt;
  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] wcnt_nxt;

  logic taken;
  logic mdu_req;
  logic load_use;
  logic jump_eff;
  logic flush_evt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    taken    = ex_branch & ex_zero;
    mdu_req  = ((state == IDLE) & mdu_start) | (state == MDU_WAIT);
    load_use = id_ex_memread & (id_ex_rt != '0) &
               ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
    jump_eff  = id_jump & ~taken & ~mdu_req & ~load_use;
    flush_evt = rst_n & (taken | jump_eff);
  end

  // Priority resolution: each lower-priority hazard only contributes when all higher ones are quiet.
  always_comb begin
    stall    = '0;
    flush    = '0;
    mdu_busy = 1'b0;
    if (rst_n) begin
      mdu_busy = (state == MDU_WAIT);
      if (taken) begin
        flush[2:1] = 2'b11;
      end else if (mdu_req) begin
        stall[2:0] = 3'b111;
        flush[3]   = 1'b1;
      end else if (load_use) begin
        stall[1:0] = 2'b11;
        flush[2]   = 1'b1;
      end else if (id_jump) begin
        flush[1]   = 1'b1;
      end
    end
  end

  // A taken branch squashes the issuing instruction, so it must not start the wait.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (mdu_start && !taken && MULTI_CYC) begin
          state_nxt = MDU_WAIT;
          wcnt_nxt  = WLOAD;
        end
      end
      MDU_WAIT: begin
        if (wcnt == '0) begin
          state_nxt = IDLE;
        end else begin
          wcnt_nxt = wcnt - WCW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Only redirecting flushes count; bubble insertion is already reflected in stall_cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (|stall) stall_cnt <= sat_inc(stall_cnt);
      if (flush_evt) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule
